macguffin_sbox_stage: RTL and testbench
=======================================

# macguffin_sbox_stage

Registered substitution stage of the MacGuffin round datapath. Sits directly downstream of the 48-bit P-box:
- takes the P-box output as eight 6-bit groups and passes each through its MacGuffin S-box (6→2 bits);
- XORs the resulting 16-bit word into the round's left (target) word;
- returns the result through a 2-entry valid/ready elastic buffer, so the round controller can stall without dropping data.

## Interface
Parameters:
- none; all widths fixed by the cipher: 48-bit P-box word, 16-bit target word, 8 S-boxes.

Ports (reset is asynchronous, active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of buffered data; takes priority over all transfers in the same cycle.
- in_valid  in  1  p_data/left_word valid.
- in_ready  out  1  stage can accept a beat.
- p_data  in  48  P-box output. Group g (g=0..7) = p_data[47-6g -: 6].
- left_word  in  16  target word to be modified.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts out_word.
- out_word  out  16  left_word ^ sbox_word.
- busy  out  1  one or more entries held.

## Operation
- sbox_word[15-2g -: 2] = SBOX[g][p_data group g], g=0..7. SBOX tables are the MacGuffin S-boxes, 64 entries × 2 bits each.
- out_word = left_word ^ sbox_word, computed combinationally at the input and stored in the buffer. No arithmetic, pure XOR; widths exact, no truncation.
- Input transfer: in_valid && in_ready at a rising edge.
- Output transfer: out_valid && out_ready at a rising edge.
- Buffer: 2 entries (head, skid), count 0..2. States EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE:
    - accept without pop → FULL.
    - pop without accept → EMPTY.
    - both → stays ONE; the new beat replaces the head.
  - FULL: pop → ONE, skid moves to head. No accept is possible because in_ready=0.
- in_ready = (count < 2). It depends only on registered state, never combinationally on out_ready.
- out_valid = (count > 0). out_word = head entry. Output is stable while out_valid && !out_ready.
- Order is strictly FIFO. No beat is lost or duplicated.
- flush: count ← 0 next cycle. A beat presented in the flush cycle is discarded. out_word data is don't-care.
- Reset (async, any time including mid-transfer):
  - count=0, out_valid=0, in_ready=1, busy=0, out_word=16'h0000;
  - all entries cleared to 0. In-flight beats are lost.

## Timing
- Latency: input accepted at edge N → out_valid=1 with the result after edge N (visible in cycle N+1).
- Throughput: one beat per cycle when out_ready is held high.
- Full-stall recovery: from FULL, a pop at edge N makes in_ready=1 in cycle N+1.
- After rst deasserts, in_ready=1 immediately. The first accept can happen at the first rising edge.
- Critical path: 6-bit table lookup + 16-bit XOR + mux into the entry register. No combinational in→out path.

## Structure
- Shared package `macguffin_pkg`:
  - typedef `sbox_table_t` (64×2-bit);
  - constant array `SBOX[0:7]`;
  - widths `BLOCK_W=64`, `WORD_W=16`, `PBOX_W=48`;
  - function `sbox_word(p_data)` used by both RTL and bench golden model.
- One sub-module: `macguffin_skid_buf`, a 2-entry valid/ready buffer with width parameter, flush and async reset. The stage is lookup/XOR + this buffer.

## Test plan
- Reset: assert rst mid-stream while FULL → same cycle out_valid=0, in_ready=1, out_word=0; after release, first accept gives correct result in the next cycle.
- Zero input: p_data=0, left_word=16'hFFFF → out_word = 16'hFFFF ^ {SBOX[0][0],…,SBOX[7][0]}. Then left_word=0 gives exactly the concatenation.
- Single-group walk: for each g, set group g to 6'h3F and others to 0, left_word=0 → only bits [15-2g -: 2] differ from the zero-input result. Repeat for all 64 values of group 0 against the table.
- Backpressure:
  - out_ready=0, send beats A=16'h1234, B, C → A, B accepted, in_ready=0 on C;
  - raise out_ready → order A, B, C with no loss; out_word held stable during the stall.
- Simultaneous accept+pop in ONE, and flush with in_valid=1 in the same cycle → flushed beat never appears; count=0 next cycle.
- Random: 10k beats with random valid/ready against the `sbox_word` golden model → zero mismatches, strict order.

Source files
------------

// File: rtl/macguffin_pkg.sv
// Shared MacGuffin definitions: S-box tables, datapath widths, the S-box word
// function and the elastic buffer state encoding.
package macguffin_pkg;

    localparam int BLOCK_W = 64;
    localparam int WORD_W  = BLOCK_W / 4;  // cipher block is four 16-bit words
    localparam int PBOX_W  = 3 * WORD_W;   // eight 6-bit groups
    localparam int N_SBOX  = 8;

    // One S-box: 64 entries of 2 bits, entry index = 6-bit group value.
    typedef logic [0:63][1:0] sbox_table_t;

    localparam sbox_table_t [0:N_SBOX-1] SBOX = '{
        '{2'd3,2'd1,2'd3,2'd0,2'd0,2'd3,2'd2,2'd2,2'd0,2'd2,2'd1,2'd3,2'd1,2'd2,2'd0,2'd1,
          2'd0,2'd3,2'd1,2'd1,2'd3,2'd0,2'd3,2'd0,2'd2,2'd1,2'd3,2'd2,2'd2,2'd1,2'd0,2'd2,
          2'd1,2'd0,2'd3,2'd2,2'd3,2'd1,2'd0,2'd2,2'd3,2'd3,2'd2,2'd1,2'd0,2'd2,2'd1,2'd0,
          2'd3,2'd3,2'd2,2'd0,2'd1,2'd2,2'd0,2'd1,2'd1,2'd2,2'd0,2'd3,2'd2,2'd0,2'd1,2'd3},
        '{2'd3,2'd0,2'd2,2'd3,2'd1,2'd2,2'd0,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd0,2'd1,2'd2,
          2'd0,2'd3,2'd1,2'd1,2'd3,2'd0,2'd2,2'd3,2'd3,2'd0,2'd0,2'd2,2'd1,2'd2,2'd2,2'd1,
          2'd0,2'd3,2'd1,2'd2,2'd2,2'd1,2'd3,2'd0,2'd1,2'd2,2'd3,2'd1,2'd2,2'd0,2'd0,2'd3,
          2'd3,2'd2,2'd2,2'd0,2'd0,2'd3,2'd1,2'd0,2'd2,2'd1,2'd1,2'd3,2'd0,2'd1,2'd3,2'd2},
        '{2'd2,2'd0,2'd2,2'd3,2'd1,2'd0,2'd3,2'd1,2'd0,2'd3,2'd3,2'd1,2'd2,2'd1,2'd0,2'd2,
          2'd3,2'd1,2'd0,2'd2,2'd0,2'd1,2'd1,2'd2,2'd0,2'd2,2'd1,2'd3,2'd3,2'd2,2'd3,2'd0,
          2'd3,2'd1,2'd1,2'd2,2'd2,2'd3,2'd0,2'd0,2'd2,2'd0,2'd0,2'd3,2'd1,2'd2,2'd3,2'd1,
          2'd0,2'd2,2'd3,2'd0,2'd1,2'd2,2'd2,2'd1,2'd1,2'd3,2'd3,2'd0,2'd2,2'd1,2'd0,2'd3},
        '{2'd1,2'd3,2'd3,2'd0,2'd0,2'd1,2'd2,2'd2,2'd0,2'd0,2'd2,2'd1,2'd2,2'd3,2'd1,2'd3,
          2'd3,2'd2,2'd2,2'd1,2'd1,2'd3,2'd0,2'd0,2'd1,2'd1,2'd0,2'd3,2'd0,2'd2,2'd3,2'd2,
          2'd2,2'd1,2'd2,2'd0,2'd3,2'd2,2'd1,2'd3,2'd3,2'd0,2'd0,2'd3,2'd1,2'd0,2'd2,2'd1,
          2'd0,2'd3,2'd0,2'd1,2'd2,2'd0,2'd3,2'd2,2'd2,2'd1,2'd1,2'd2,2'd3,2'd1,2'd0,2'd3},
        '{2'd0,2'd3,2'd1,2'd0,2'd1,2'd2,2'd2,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd0,2'd3,2'd2,
          2'd3,2'd2,2'd0,2'd3,2'd1,2'd1,2'd3,2'd0,2'd1,2'd0,2'd3,2'd2,2'd0,2'd2,2'd2,2'd1,
          2'd1,2'd0,2'd0,2'd2,2'd2,2'd3,2'd1,2'd2,2'd3,2'd2,2'd3,2'd1,2'd1,2'd0,2'd0,2'd3,
          2'd2,2'd2,2'd3,2'd1,2'd0,2'd3,2'd0,2'd3,2'd1,2'd3,2'd0,2'd2,2'd2,2'd1,2'd1,2'd0},
        '{2'd3,2'd0,2'd2,2'd3,2'd2,2'd0,2'd1,2'd2,2'd0,2'd3,2'd0,2'd1,2'd3,2'd1,2'd1,2'd2,
          2'd2,2'd3,2'd1,2'd0,2'd1,2'd3,2'd2,2'd1,2'd1,2'd0,2'd3,2'd3,2'd0,2'd2,2'd0,2'd2,
          2'd2,2'd3,2'd3,2'd1,2'd0,2'd2,2'd3,2'd0,2'd1,2'd0,2'd1,2'd2,2'd0,2'd3,2'd2,2'd1,
          2'd1,2'd0,2'd0,2'd3,2'd2,2'd1,2'd3,2'd2,2'd2,2'd3,2'd0,2'd1,2'd1,2'd0,2'd2,2'd3},
        '{2'd1,2'd2,2'd0,2'd3,2'd3,2'd0,2'd2,2'd3,2'd0,2'd3,2'd2,2'd1,2'd1,2'd2,2'd1,2'd0,
          2'd3,2'd0,2'd2,2'd1,2'd1,2'd2,2'd0,2'd2,2'd3,2'd0,2'd1,2'd3,2'd0,2'd3,2'd2,2'd1,
          2'd0,2'd1,2'd2,2'd3,2'd3,2'd0,2'd1,2'd3,2'd2,2'd3,2'd1,2'd2,2'd0,2'd1,2'd2,2'd0,
          2'd1,2'd2,2'd3,2'd2,2'd0,2'd1,2'd2,2'd1,2'd2,2'd1,2'd0,2'd3,2'd3,2'd0,2'd0,2'd3},
        '{2'd3,2'd0,2'd2,2'd1,2'd1,2'd3,2'd2,2'd0,2'd2,2'd2,2'd0,2'd3,2'd1,2'd0,2'd3,2'd1,
          2'd0,2'd3,2'd3,2'd2,2'd2,2'd0,2'd1,2'd1,2'd3,2'd1,2'd1,2'd2,2'd0,2'd3,2'd2,2'd0,
          2'd1,2'd2,2'd1,2'd0,2'd2,2'd3,2'd3,2'd0,2'd0,2'd1,2'd2,2'd3,2'd3,2'd0,2'd1,2'd2,
          2'd0,2'd0,2'd3,2'd1,2'd1,2'd2,2'd2,2'd3,2'd3,2'd3,2'd2,2'd0,2'd0,2'd1,2'd1,2'd2}
    };

    // 16-bit S-box output: group g = p[47-6g -: 6] selects bits [15-2g -: 2].
    function automatic logic [WORD_W-1:0] sbox_word(input logic [PBOX_W-1:0] p);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int g = 0; g < N_SBOX; g++) begin
            w[WORD_W-1-2*g -: 2] = SBOX[g][p[PBOX_W-1-6*g -: 6]];
        end
        return w;
    endfunction

    // Occupancy of the 2-entry elastic buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/macguffin_sbox_stage_if.sv
// Handshake bundle of the S-box stage: input beat, output beat, flush and busy.
interface macguffin_sbox_stage_if;
    import macguffin_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PBOX_W-1:0] p_data;
    logic [WORD_W-1:0] left_word;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;
    logic              busy;

    // Round controller side.
    modport master (
        output flush, in_valid, p_data, left_word, out_ready,
        input  in_ready, out_valid, out_word, busy
    );

    // Stage side.
    modport slave (
        input  flush, in_valid, p_data, left_word, out_ready,
        output in_ready, out_valid, out_word, busy
    );
endinterface

// File: rtl/macguffin_skid_buf.sv
// Two-entry valid/ready elastic buffer (head + skid). All outputs are
// registered, so in_ready never depends combinationally on out_ready.
module macguffin_skid_buf
    import macguffin_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    buf_state_t   state_reg;
    logic [W-1:0] head_reg;
    logic [W-1:0] skid_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;

    logic push;
    logic pop;

    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid_reg && out_ready;

    // Occupancy FSM with registered handshake outputs; flush beats any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= BUF_EMPTY;
            head_reg      <= '0;
            skid_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (flush) begin
            state_reg     <= BUF_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (push) begin
                        head_reg      <= in_data;
                        state_reg     <= BUF_ONE;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new beat takes its place.
                        head_reg <= in_data;
                    end else if (push) begin
                        skid_reg     <= in_data;
                        state_reg    <= BUF_FULL;
                        in_ready_reg <= 1'b0;
                    end else if (pop) begin
                        state_reg     <= BUF_EMPTY;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        head_reg     <= skid_reg;
                        state_reg    <= BUF_ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= BUF_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = head_reg;
    assign busy      = busy_reg;

endmodule

// File: rtl/macguffin_sbox_stage.sv
// MacGuffin substitution stage: eight 6->2 S-box lookups on the P-box word,
// XOR into the left word, result held in a 2-entry elastic buffer.
module macguffin_sbox_stage
    import macguffin_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    macguffin_sbox_stage_if.slave bus
);

    logic [WORD_W-1:0] result_next;

    // Lookup + XOR is purely combinational and lands directly in the buffer entry.
    always_comb begin
        result_next = bus.left_word ^ sbox_word(bus.p_data);
    end

    macguffin_skid_buf #(
        .W (WORD_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (result_next),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_word),
        .busy      (bus.busy)
    );

endmodule

// File: tb/tb_macguffin_sbox_stage.sv
// Directed + random bench for macguffin_sbox_stage with a FIFO scoreboard.
module tb_macguffin_sbox_stage;
    import macguffin_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [15:0] q[$];

    macguffin_sbox_stage_if bus ();

    macguffin_sbox_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table entry 63 of each S-box, written out independently of the package.
    localparam logic [1:0] TOP_ENTRY [0:7] = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check state against the scoreboard, update it.
    task automatic step_x(input logic iv, input logic [47:0] pd, input logic [15:0] lw,
                          input logic ordy, input logic fl, input logic [15:0] exp);
        bus.in_valid  = iv;
        bus.p_data    = pd;
        bus.left_word = lw;
        bus.out_ready = ordy;
        bus.flush     = fl;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
        check("busy",      32'(bus.busy),      32'(q.size() != 0));
        if (bus.out_valid && q.size() != 0)
            check("out_word", 32'(bus.out_word), 32'(q[0]));
        if (fl) begin
            q.delete();
        end else begin
            if (bus.out_valid && ordy && q.size() != 0) void'(q.pop_front());
            if (iv && bus.in_ready) q.push_back(exp);
        end
        @(posedge clk);
        #1;
        $display("[TB] cyc iv=%0b ordy=%0b fl=%0b lw=%h exp=%h out_v=%0b out=%h",
                 iv, ordy, fl, lw, exp, bus.out_valid, bus.out_word);
    endtask

    task automatic send(input logic iv, input logic [47:0] pd, input logic [15:0] lw,
                        input logic ordy, input logic fl);
        step_x(iv, pd, lw, ordy, fl, lw ^ sbox_word(pd));
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) send(1'b0, 48'h0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [15:0] e;
        logic [47:0] pd;
        logic [15:0] lw;
        logic        iv;
        logic        ordy;
        int          sent;
        int          cyc;

        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.p_data = '0; bus.left_word = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_out_word",  32'(bus.out_word),  32'h0);
        rst = 1'b0;

        // Zero input against hard-coded S-box concatenation 16'hF937.
        step_x(1'b1, 48'h0, 16'hFFFF, 1'b1, 1'b0, 16'h06C8);
        step_x(1'b1, 48'h0, 16'h0000, 1'b1, 1'b0, 16'hF937);
        step_x(1'b1, 48'hFFFF_FFFF_FFFF, 16'h0000, 1'b1, 1'b0, 16'hEF3E);
        drain();

        // Single-group walk: only the selected group's two bits move.
        for (int g = 0; g < 8; g++) begin
            pd = 48'h3F << (42 - 6 * g);
            e = 16'hF937;
            e[15 - 2 * g -: 2] = TOP_ENTRY[g];
            step_x(1'b1, pd, 16'h0, 1'b1, 1'b0, e);
        end
        // Every value of group 0 against its table, back to back.
        for (int v = 0; v < 64; v++) begin
            pd = 48'(v) << 42;
            e = 16'hF937;
            e[15:14] = SBOX[0][v];
            step_x(1'b1, pd, 16'h0, 1'b1, 1'b0, e);
        end
        drain();

        // Backpressure: A, B fill the buffer, C must wait; order preserved.
        step_x(1'b1, 48'h0, 16'h1234, 1'b0, 1'b0, 16'hEB03);
        step_x(1'b1, 48'h0, 16'h5678, 1'b0, 1'b0, 16'hAF4F);
        check("c_blocked", 32'(bus.in_ready), 32'd0);
        step_x(1'b1, 48'hFFFF_FFFF_FFFF, 16'h9ABC, 1'b0, 1'b0, 16'h7582);
        step_x(1'b1, 48'hFFFF_FFFF_FFFF, 16'h9ABC, 1'b0, 1'b0, 16'h7582);
        check("stall_hold", 32'(bus.out_word), 32'h0000_EB03);
        step_x(1'b1, 48'hFFFF_FFFF_FFFF, 16'h9ABC, 1'b1, 1'b0, 16'h7582);
        check("recover_ready", 32'(bus.in_ready), 32'd1);
        step_x(1'b1, 48'hFFFF_FFFF_FFFF, 16'h9ABC, 1'b1, 1'b0, 16'h7582);
        drain();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Flush with a beat presented in the same cycle.
        send(1'b1, 48'h1111_2222_3333, 16'hA5A5, 1'b0, 1'b0);
        send(1'b1, 48'h4444_5555_6666, 16'h5A5A, 1'b0, 1'b1);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_busy",  32'(bus.busy),      32'd0);
        send(1'b1, 48'h7777_8888_9999, 16'h0F0F, 1'b1, 1'b0);
        drain();

        // Async reset while FULL.
        send(1'b1, 48'hABCD_EF01_2345, 16'h1111, 1'b0, 1'b0);
        send(1'b1, 48'h6789_ABCD_EF01, 16'h2222, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        check("mid_rst_word",  32'(bus.out_word),  32'h0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_x(1'b1, 48'h0, 16'hFFFF, 1'b1, 1'b0, 16'h06C8);
        drain();

        // Random traffic against the golden function.
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            pd   = {16'($urandom), $urandom};
            lw   = 16'($urandom);
            if (iv && bus.in_ready) sent++;
            send(iv, pd, lw, ordy, 1'b0);
            cyc++;
        end
        check("random_beats", 32'(sent), 32'd10000);
        drain();
        check("random_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
